// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls a branch until its operands are obtainable, picks forwarding, redirects PC.
// Latency: resolves in the same cycle when no hazard; a load in EX costs 2 stall cycles (resolve on the 3rd).
// Backpressure: holds PC and IF/ID and bubbles ID/EX while stalling; exc_flush overrides everything.
module branch_hazard_ctrl #(
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_branch,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_memread,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_wb_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_branch_taken,
  input  logic             i_exc_flush,
  input  logic             i_stat_clr,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_idex_bubble,
  output logic             o_pc_src_branch,
  output logic             o_ifid_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stat_branches,
  output logic [CNT_W-1:0] o_stat_taken,
  output logic [CNT_W-1:0] o_stat_stall_cycles
);

  typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_cnt;
  logic       w_cnt_nxt;
  logic       w_resolve;
  logic [1:0] w_h_rs;
  logic [1:0] w_h_rt;
  logic [1:0] w_h;

  // Stall depth a register still needs: a load in EX needs 2 cycles, ALU result in EX or load in MEM needs 1.
  function automatic logic [1:0] f_depth(input logic [4:0] r,
                                         input logic ex_rw, input logic ex_mr, input logic [4:0] ex_rd,
                                         input logic mem_rw, input logic mem_mr, input logic [4:0] mem_rd);
    if (r == 5'd0)                      return 2'd0;
    if (ex_rw && ex_rd == r)            return ex_mr ? 2'd2 : 2'd1;
    if (mem_rw && mem_mr && mem_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  // Operand source once the branch resolves; MEM (non-load) result is younger than WB so it wins.
  function automatic logic [1:0] f_fwd(input logic [4:0] r,
                                       input logic mem_rw, input logic mem_mr, input logic [4:0] mem_rd,
                                       input logic wb_rw, input logic [4:0] wb_rd);
    if (r == 5'd0)                        return 2'b00;
    if (mem_rw && !mem_mr && mem_rd == r) return 2'b01;
    if (wb_rw && wb_rd == r)              return 2'b10;
    return 2'b00;
  endfunction

  assign w_h_rs = f_depth(i_id_rs, i_ex_regwrite, i_ex_memread, i_ex_rd,
                          i_mem_regwrite, i_mem_memread, i_mem_rd);
  assign w_h_rt = i_id_uses_rt ? f_depth(i_id_rt, i_ex_regwrite, i_ex_memread, i_ex_rd,
                                         i_mem_regwrite, i_mem_memread, i_mem_rd) : 2'd0;
  assign w_h    = (w_h_rs > w_h_rt) ? w_h_rs : w_h_rt;
  assign o_busy = (r_state == S_STALL);

  // State and stall countdown registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control outputs; everything is quiet during reset or an exception flush.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_resolve       = 1'b0;
    o_pc_stall      = 1'b0;
    o_ifid_stall    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_pc_src_branch = 1'b0;
    o_ifid_flush    = 1'b0;
    o_fwd_a         = 2'b00;
    o_fwd_b         = 2'b00;
    if (!i_rst_n) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 1'b0;
    end else if (i_exc_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_id_branch) begin
            if (w_h != 2'd0) begin
              o_pc_stall    = 1'b1;
              o_ifid_stall  = 1'b1;
              o_idex_bubble = 1'b1;
              if (w_h == 2'd2) begin
                w_cnt_nxt   = 1'b1;
                w_state_nxt = S_STALL;
              end
            end else begin
              w_resolve       = 1'b1;
              o_pc_src_branch = i_branch_taken;
              o_ifid_flush    = i_branch_taken & (DELAY_SLOT == 0);
              o_fwd_a         = f_fwd(i_id_rs, i_mem_regwrite, i_mem_memread, i_mem_rd,
                                      i_wb_regwrite, i_wb_rd);
              o_fwd_b         = i_id_uses_rt ? f_fwd(i_id_rt, i_mem_regwrite, i_mem_memread, i_mem_rd,
                                                     i_wb_regwrite, i_wb_rd) : 2'b00;
            end
          end
        end
        S_STALL: begin
          // Committed stall: inputs are not re-evaluated until the countdown expires.
          o_pc_stall    = 1'b1;
          o_ifid_stall  = 1'b1;
          o_idex_bubble = 1'b1;
          w_cnt_nxt     = r_cnt - 1'b1;
          if (w_cnt_nxt == 1'b0) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; a clear wins over any increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_branches     <= '0;
      o_stat_taken        <= '0;
      o_stat_stall_cycles <= '0;
    end else if (i_stat_clr) begin
      o_stat_branches     <= '0;
      o_stat_taken        <= '0;
      o_stat_stall_cycles <= '0;
    end else begin
      if (w_resolve && o_stat_branches != CNT_MAX)
        o_stat_branches <= o_stat_branches + CNT_ONE;
      if (w_resolve && i_branch_taken && o_stat_taken != CNT_MAX)
        o_stat_taken <= o_stat_taken + CNT_ONE;
      if (o_pc_stall && o_stat_stall_cycles != CNT_MAX)
        o_stat_stall_cycles <= o_stat_stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;
  logic clk, rst_n;
  logic id_branch, id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic branch_taken, exc_flush, stat_clr;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;

  logic a_pc_stall, a_ifid_stall, a_idex_bubble, a_pc_src, a_ifid_flush, a_busy;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [31:0] a_br, a_tk, a_st;
  logic b_pc_stall, b_ifid_stall, b_idex_bubble, b_pc_src, b_ifid_flush, b_busy;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [3:0] b_br, b_tk, b_st;

  int n_pass = 0;
  int n_total = 0;

  branch_hazard_ctrl dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_branch(id_branch), .i_id_uses_rt(id_uses_rt),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
    .i_ex_rd(ex_rd), .i_mem_regwrite(mem_regwrite), .i_mem_memread(mem_memread), .i_mem_rd(mem_rd),
    .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_branch_taken(branch_taken),
    .i_exc_flush(exc_flush), .i_stat_clr(stat_clr),
    .o_pc_stall(a_pc_stall), .o_ifid_stall(a_ifid_stall), .o_idex_bubble(a_idex_bubble),
    .o_pc_src_branch(a_pc_src), .o_ifid_flush(a_ifid_flush), .o_fwd_a(a_fwd_a), .o_fwd_b(a_fwd_b),
    .o_busy(a_busy), .o_stat_branches(a_br), .o_stat_taken(a_tk), .o_stat_stall_cycles(a_st)
  );

  branch_hazard_ctrl #(.DELAY_SLOT(1), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_branch(id_branch), .i_id_uses_rt(id_uses_rt),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
    .i_ex_rd(ex_rd), .i_mem_regwrite(mem_regwrite), .i_mem_memread(mem_memread), .i_mem_rd(mem_rd),
    .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_branch_taken(branch_taken),
    .i_exc_flush(exc_flush), .i_stat_clr(stat_clr),
    .o_pc_stall(b_pc_stall), .o_ifid_stall(b_ifid_stall), .o_idex_bubble(b_idex_bubble),
    .o_pc_src_branch(b_pc_src), .o_ifid_flush(b_ifid_flush), .o_fwd_a(b_fwd_a), .o_fwd_b(b_fwd_b),
    .o_busy(b_busy), .o_stat_branches(b_br), .o_stat_taken(b_tk), .o_stat_stall_cycles(b_st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    id_branch = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0;
    branch_taken = 0; exc_flush = 0; stat_clr = 0;
  endtask

  // Drive at the falling edge, sample 2 ns later (well before the next rising edge).
  task automatic next_step();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    // Reset: outputs forced low even with a ready taken branch present.
    id_branch = 1; id_uses_rt = 1; id_rs = 1; id_rt = 2; branch_taken = 1;
    #1;
    chk("rst_pc_src", a_pc_src, 0);
    chk("rst_flush", a_ifid_flush, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_stats", {a_br[7:0], a_tk[7:0], a_st[7:0]}, 0);
    next_step();
    rst_n = 1'b1;

    // 1. beq $1,$2 taken, nothing in flight.
    next_step();
    id_branch = 1; id_uses_rt = 1; id_rs = 1; id_rt = 2; branch_taken = 1;
    #2;
    chk("t1_pc_src", a_pc_src, 1);
    chk("t1_flush", a_ifid_flush, 1);
    chk("t1_stall", a_pc_stall, 0);
    chk("t1_fwd", {a_fwd_a, a_fwd_b}, 4'b0000);
    next_step();
    #2;
    chk("t1_taken", a_tk, 1);
    chk("t1_branches", a_br, 1);

    // 2. lw $3 in EX, bne $3,$0: two stall cycles then resolve with WB forwarding.
    next_step();
    id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 0; branch_taken = 1;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    #2;
    chk("t2_c1_stall", {a_pc_stall, a_ifid_stall, a_idex_bubble}, 3'b111);
    chk("t2_c1_busy", a_busy, 0);
    chk("t2_c1_pc_src", a_pc_src, 0);
    next_step();
    id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 0; branch_taken = 1;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 3;
    #2;
    chk("t2_c2_stall", {a_pc_stall, a_ifid_stall, a_idex_bubble}, 3'b111);
    chk("t2_c2_busy", a_busy, 1);
    next_step();
    id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 0; branch_taken = 1;
    wb_regwrite = 1; wb_rd = 3;
    #2;
    chk("t2_c3_stall", a_pc_stall, 0);
    chk("t2_c3_busy", a_busy, 0);
    chk("t2_c3_fwd_a", a_fwd_a, 2'b10);
    chk("t2_c3_fwd_b", a_fwd_b, 2'b00);
    chk("t2_c3_pc_src", a_pc_src, 1);
    next_step();
    #2;
    chk("t2_stall_cycles", a_st, 2);
    chk("t2_branches", a_br, 2);

    // Clear statistics on an idle cycle.
    next_step();
    stat_clr = 1;
    next_step();
    #2;
    chk("clr_stats", {a_br[7:0], a_tk[7:0], a_st[7:0]}, 0);

    // 3. add $4 in EX, bgtz $4: one stall, then MEM forwarding (MEM beats WB).
    next_step();
    id_branch = 1; id_uses_rt = 0; id_rs = 4; id_rt = 4; ex_regwrite = 1; ex_rd = 4;
    #2;
    chk("t3_c1_stall", a_pc_stall, 1);
    chk("t3_c1_busy", a_busy, 0);
    next_step();
    id_branch = 1; id_uses_rt = 0; id_rs = 4; id_rt = 4;
    mem_regwrite = 1; mem_rd = 4; wb_regwrite = 1; wb_rd = 4;
    #2;
    chk("t3_c2_stall", a_pc_stall, 0);
    chk("t3_c2_fwd_a", a_fwd_a, 2'b01);
    chk("t3_c2_fwd_b", a_fwd_b, 2'b00);
    chk("t3_c2_pc_src", a_pc_src, 0);
    next_step();
    #2;
    chk("t3_stall_cycles", a_st, 1);
    chk("t3_branches", a_br, 1);
    chk("t3_taken", a_tk, 0);

    // 4. exc_flush while in STALL.
    next_step();
    id_branch = 1; id_rs = 5; ex_regwrite = 1; ex_memread = 1; ex_rd = 5; branch_taken = 1;
    #2;
    chk("t4_c1_stall", a_pc_stall, 1);
    next_step();
    id_branch = 1; id_rs = 5; mem_regwrite = 1; mem_memread = 1; mem_rd = 5; exc_flush = 1;
    #2;
    chk("t4_flush_ctrl", {a_pc_stall, a_ifid_stall, a_idex_bubble, a_pc_src, a_ifid_flush}, 5'b0);
    next_step();
    #2;
    chk("t4_after_busy", a_busy, 0);
    chk("t4_after_stall", a_pc_stall, 0);
    chk("t4_stats", {a_br[7:0], a_tk[7:0], a_st[7:0]}, {8'd1, 8'd0, 8'd2});

    // 5. Delay-slot instance, taken, and $0 writers never stall or forward.
    next_step();
    id_branch = 1; id_uses_rt = 1; id_rs = 0; id_rt = 0; branch_taken = 1;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 0; wb_regwrite = 1; wb_rd = 0;
    #2;
    chk("t5_b_stall", b_pc_stall, 0);
    chk("t5_b_pc_src", b_pc_src, 1);
    chk("t5_b_flush", b_ifid_flush, 0);
    chk("t5_b_fwd", {b_fwd_a, b_fwd_b}, 4'b0000);
    chk("t5_a_flush", a_ifid_flush, 1);

    // 6. Saturation on the 4-bit instance, then clear concurrent with a taken branch.
    next_step();
    stat_clr = 1;
    for (int i = 0; i < 20; i++) begin
      next_step();
      id_branch = 1; id_rs = 6; id_rt = 7; id_uses_rt = 1; branch_taken = 1;
    end
    next_step();
    #2;
    chk("t6_b_taken_sat", b_tk, 4'hF);
    chk("t6_b_branches_sat", b_br, 4'hF);
    chk("t6_a_taken", a_tk, 20);
    next_step();
    id_branch = 1; id_rs = 6; branch_taken = 1; stat_clr = 1;
    next_step();
    #2;
    chk("t6_b_clr_taken", b_tk, 0);
    chk("t6_b_clr_branches", b_br, 0);
    chk("t6_a_clr_taken", a_tk, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
